// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flush
// and data-memory wait freezing, with stall and timeout bookkeeping.
module hazard_control_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MAX_WAIT          = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write_en,
    output logic        fd_write_en,
    output logic        fd_flush,
    output logic        de_bubble,
    output logic [1:0]  state,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_e;

    localparam logic [2:0] BUB_LOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    state_e      state_q, state_d;
    logic [2:0]  bub_q, bub_d;
    logic [7:0]  wait_q, wait_d;
    logic        tmo_q, tmo_d;
    logic [31:0] stall_q;
    logic        hz, mem_stall, issue;

    assign hz = ex_mem_read & (ex_rd != 5'd0) &
                ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
    assign mem_stall = mem_req & ~mem_ready;

    always_comb begin
        state_d     = state_q;
        bub_d       = bub_q;
        wait_d      = wait_q;
        tmo_d       = tmo_q;
        pc_write_en = 1'b1;
        fd_write_en = 1'b1;
        fd_flush    = 1'b0;
        de_bubble   = 1'b0;
        issue       = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    pc_write_en = 1'b0;
                    fd_write_en = 1'b0;
                    state_d     = MEM_WAIT;
                    wait_d      = 8'd1;
                end else begin
                    issue = 1'b1;
                end
            end
            LOAD_STALL: begin
                if (mem_stall) begin
                    pc_write_en = 1'b0;
                    fd_write_en = 1'b0;
                    state_d     = MEM_WAIT;
                    wait_d      = 8'd1;
                    bub_d       = 3'd0;
                end else begin
                    pc_write_en = 1'b0;
                    fd_write_en = 1'b0;
                    de_bubble   = 1'b1;
                    bub_d       = bub_q - 3'd1;
                    if (bub_q == 3'd1) state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    pc_write_en = 1'b0;
                    fd_write_en = 1'b0;
                    if (wait_q != 8'hFF) wait_d = wait_q + 8'd1;
                    if (wait_d == WAIT_MAX) tmo_d = 1'b1;
                end else begin
                    wait_d  = 8'd0;
                    state_d = RUN;
                    issue   = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        // Shared decision for RUN and the MEM_WAIT release cycle
        if (issue) begin
            if (branch_taken) begin
                fd_flush  = 1'b1;
                de_bubble = 1'b1;
            end else if (hz) begin
                pc_write_en = 1'b0;
                fd_write_en = 1'b0;
                de_bubble   = 1'b1;
                bub_d       = BUB_LOAD;
                state_d     = (BUB_LOAD != 3'd0) ? LOAD_STALL : RUN;
            end
        end
        if (!rst_n) begin
            pc_write_en = 1'b0;
            fd_write_en = 1'b1;
            fd_flush    = 1'b1;
            de_bubble   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            bub_q   <= 3'd0;
            wait_q  <= 8'd0;
            tmo_q   <= 1'b0;
            stall_q <= 32'd0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
            if (!pc_write_en) stall_q <= stall_q + 32'd1;
        end
    end

    assign state        = state_q;
    assign mem_timeout  = tmo_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: two parameterisations
// share stimulus; each phase checks one of them after a reset.
module tb_hazard_control_unit;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic id_uses_rt, ex_mem_read, branch_taken, mem_req, mem_ready;

    logic [1:0] pc_w, fd_w, fl_w, bb_w, to_w;
    logic [1:0] st_w [2];
    logic [31:0] sc_w [2];

    typedef struct {
        int          d;
        logic [3:0]  ctl;
        logic [1:0]  st;
        logic [31:0] sc;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;
    int n_step = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.LOAD_STALL_CYCLES(1), .MAX_WAIT(16)) u_a (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write_en(pc_w[0]), .fd_write_en(fd_w[0]),
        .fd_flush(fl_w[0]), .de_bubble(bb_w[0]), .state(st_w[0]),
        .mem_timeout(to_w[0]), .stall_cycles(sc_w[0])
    );

    hazard_control_unit #(.LOAD_STALL_CYCLES(3), .MAX_WAIT(2)) u_b (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write_en(pc_w[1]), .fd_write_en(fd_w[1]),
        .fd_flush(fl_w[1]), .de_bubble(bb_w[1]), .state(st_w[1]),
        .mem_timeout(to_w[1]), .stall_cycles(sc_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic r, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt,
                       input logic mr, input logic [4:0] rd,
                       input logic br, input logic mq, input logic my);
        rst_n = r; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_mem_read = mr; ex_rd = rd; branch_taken = br;
        mem_req = mq; mem_ready = my;
    endtask

    task automatic idle();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Push expectation for the current cycle, then pop and compare
    task automatic step(input int d, input logic [3:0] ctl,
                        input logic [1:0] st, input int sc,
                        input logic to);
        exp_t e;
        exp_t g;
        e.d = d; e.ctl = ctl; e.st = st; e.sc = sc; e.to = to;
        sb.push_back(e);
        #2;
        g = sb.pop_front();
        n_step++;
        chk($sformatf("s%0d.ctl", n_step),
            {28'd0, pc_w[g.d], fd_w[g.d], fl_w[g.d], bb_w[g.d]},
            {28'd0, g.ctl});
        chk($sformatf("s%0d.state", n_step), {30'd0, st_w[g.d]},
            {30'd0, g.st});
        chk($sformatf("s%0d.stall", n_step), sc_w[g.d], g.sc);
        chk($sformatf("s%0d.tmo", n_step), {31'd0, to_w[g.d]},
            {31'd0, g.to});
        @(negedge clk);
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        // Phase A: LOAD_STALL_CYCLES=1, MAX_WAIT=16
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); step(0, 4'b0111, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0); step(0, 4'b0000, 0, 0, 0);
        step(0, 4'b0000, 2, 1, 0);
        step(0, 4'b0000, 2, 2, 0);
        step(0, 4'b0000, 2, 3, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 1); step(0, 4'b1100, 2, 4, 0);
        idle();                         step(0, 4'b1100, 0, 4, 0);
        drv(1, 5, 0, 0, 1, 5, 0, 0, 0); step(0, 4'b0001, 0, 4, 0);
        idle();                         step(0, 4'b1100, 0, 5, 0);
        drv(1, 5, 0, 0, 1, 5, 1, 0, 0); step(0, 4'b1111, 0, 5, 0);
        idle();                         step(0, 4'b1100, 0, 5, 0);
        drv(1, 0, 0, 0, 1, 0, 0, 0, 0); step(0, 4'b1100, 0, 5, 0);
        drv(1, 1, 7, 0, 1, 7, 0, 0, 0); step(0, 4'b1100, 0, 5, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0); step(0, 4'b0000, 0, 5, 0);
        drv(1, 5, 0, 0, 1, 5, 0, 1, 1); step(0, 4'b0001, 2, 6, 0);
        idle();                         step(0, 4'b1100, 0, 7, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0); step(0, 4'b0000, 0, 7, 0);
        step(0, 4'b0000, 2, 8, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0); step(0, 4'b0111, 2, 9, 0);
        step(0, 4'b0111, 0, 0, 0);
        idle();                         step(0, 4'b1100, 0, 0, 0);
        // Phase B: LOAD_STALL_CYCLES=3, MAX_WAIT=2
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        step(1, 4'b0111, 0, 0, 0);
        drv(1, 0, 0, 0, 1, 0, 0, 0, 0); step(1, 4'b1100, 0, 0, 0);
        drv(1, 3, 7, 1, 1, 7, 0, 0, 0); step(1, 4'b0001, 0, 0, 0);
        idle();                         step(1, 4'b0001, 1, 1, 0);
        drv(1, 0, 0, 0, 0, 0, 1, 0, 0); step(1, 4'b0001, 1, 2, 0);
        idle();                         step(1, 4'b1100, 0, 3, 0);
        drv(1, 3, 7, 1, 1, 7, 0, 0, 0); step(1, 4'b0001, 0, 3, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0); step(1, 4'b0000, 1, 4, 0);
        step(1, 4'b0000, 2, 5, 0);
        step(1, 4'b0000, 2, 6, 1);
        step(1, 4'b0000, 2, 7, 1);
        step(1, 4'b0000, 2, 8, 1);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 1); step(1, 4'b1100, 2, 9, 1);
        idle();                         step(1, 4'b1100, 0, 9, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0); step(1, 4'b0111, 0, 9, 1);
        idle();                         step(1, 4'b1100, 0, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
